ip_codma_bus_responder: RTL and testbench

//  - Target-side end of the CODMA bus: answers the DMA engine's read/write requests from a local word memory.
//  - Grants each request, streams single-word or 8-word bursts, and flags illegal accesses with bus_error.
//  - Sits behind the bus as the memory/peripheral model the DMA read and write phases talk to.

---
 rtl/ip_codma_pkg.sv | 22 ++
 rtl/ip_codma_resp_mem.sv | 29 ++
 rtl/ip_codma_bus_responder.sv | 221 ++++++++++++++++++++++
 tb/tb_ip_codma_bus_responder.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ip_codma_pkg.sv
// Shared CODMA bus constants and the responder state type.
// The initiator-side read/write machines import the same size codes and burst length.
package ip_codma_pkg;

  localparam logic [3:0]  SIZE_WORD  = 4'd4;
  localparam logic [3:0]  SIZE_BURST = 4'd9;
  localparam int unsigned BURST_LEN  = 8;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    BEAT,
    RELEASE,
    ERR
  } resp_state_t;

  // Index of the final beat for a size code; anything that is not a burst is a single word.
  function automatic logic [2:0] last_beat_of(input logic [3:0] size);
    return (size == SIZE_BURST) ? 3'(BURST_LEN - 1) : 3'd0;
  endfunction

endpackage

// File: rtl/ip_codma_resp_mem.sv
// Single-port synchronous word RAM behind the CODMA responder.
// Ports:
//   clk_i  - clock, rising edge
//   we     - write enable; writes wdata to addr
//   addr   - word address, shared by read and write
//   wdata  - write data
//   rdata  - registered read data of addr, valid the cycle after the access
// Contents are not reset.
module ip_codma_resp_mem #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic          clk_i,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/ip_codma_bus_responder.sv
// Target-side end of the CODMA bus: grants DMA requests, streams single-word or
// 8-word bursts to/from a local word memory, and rejects illegal accesses.
// Ports:
//   clk_i, rstn_i     - clock (rising edge), asynchronous active-low reset
//   bus_request       - initiator request, held for the whole transaction
//   bus_read_write    - 0 read / 1 write, sampled with the request
//   bus_addr          - byte address of first word, sampled with the request
//   bus_size          - SIZE_WORD (1 word) or SIZE_BURST (8 words)
//   bus_data_write    - write data for the current beat
//   bus_grant         - high from accept to last beat
//   bus_valid         - per-beat strobe (read data valid / write data consumed)
//   bus_data_read     - read data, zero outside read beats
//   bus_error         - one-cycle pulse on a rejected request
//   busy_o            - state != IDLE
//   err_count_o       - saturating count of error pulses
// Build option: define CODMA_RESP_WAIT_EN to insert WAIT_CYCLES stall cycles
// before every beat; without it the wait counter does not exist.
//
// state   | meaning
// IDLE    | waiting for bus_request; request fields captured on entry to CHECK
// CHECK   | one cycle legality check of the captured request
// BEAT    | grant held; waits (optional) and data beats, abort on request drop
// RELEASE | transaction over; wait for the initiator to drop bus_request
// ERR     | one-cycle bus_error pulse, error counter bump
module ip_codma_bus_responder
  import ip_codma_pkg::*;
#(
  parameter int unsigned MEM_WORDS   = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        bus_request,
  input  logic        bus_read_write,
  input  logic [31:0] bus_addr,
  input  logic [3:0]  bus_size,
  input  logic [31:0] bus_data_write,
  output logic        bus_grant,
  output logic        bus_valid,
  output logic [31:0] bus_data_read,
  output logic        bus_error,
  output logic        busy_o,
  output logic [7:0]  err_count_o
);

  localparam int unsigned AW = $clog2(MEM_WORDS);

  resp_state_t state_q, state_d;
  logic        rw_q;
  logic [31:0] addr_q;
  logic [3:0]  size_q;
  logic [2:0]  last_beat_q;
  logic [2:0]  beat_q, beat_d;
  logic        grant_q, grant_d;
  logic        valid_q, valid_d;
  logic        error_q, error_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  logic          req_legal;
  logic [32:0]   span_end;
  logic [AW-1:0] idx_q;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_rdata;

`ifdef CODMA_RESP_WAIT_EN
  localparam int unsigned WW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  logic [WW-1:0] wait_q, wait_d;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end
`endif

  // Word index plus beat count, computed wide so addresses far past the memory
  // cannot wrap into range.
  assign span_end  = {3'b000, addr_q[31:2]} + 33'(last_beat_q) + 33'd1;
  assign req_legal = (addr_q[1:0] == 2'b00)
                   && ((size_q == SIZE_WORD) || (size_q == SIZE_BURST))
                   && (span_end <= 33'(MEM_WORDS));

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    valid_d   = valid_q;
    beat_d    = beat_q;
    error_d   = 1'b0;
    err_cnt_d = err_cnt_q;
`ifdef CODMA_RESP_WAIT_EN
    wait_d    = wait_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus_request) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (req_legal) begin
          state_d = BEAT;
          grant_d = 1'b1;
          valid_d = 1'b0;
          beat_d  = 3'd0;
`ifdef CODMA_RESP_WAIT_EN
          wait_d  = WW'(WAIT_CYCLES);
`endif
        end else begin
          state_d = ERR;
          error_d = 1'b1;
        end
      end
      BEAT: begin
        if (!bus_request) begin
          state_d = IDLE;
          grant_d = 1'b0;
          valid_d = 1'b0;
        end else if (valid_q) begin
          if (beat_q == last_beat_q) begin
            state_d = RELEASE;
            grant_d = 1'b0;
            valid_d = 1'b0;
          end else begin
            beat_d = beat_q + 3'd1;
`ifdef CODMA_RESP_WAIT_EN
            // The cycle after a beat already counts as the first stall cycle.
            if (WAIT_CYCLES != 0) begin
              valid_d = 1'b0;
              wait_d  = WW'(WAIT_CYCLES - 1);
            end else begin
              valid_d = 1'b1;
            end
`else
            valid_d = 1'b1;
`endif
          end
        end else begin
`ifdef CODMA_RESP_WAIT_EN
          if (wait_q == '0) begin
            valid_d = 1'b1;
          end else begin
            wait_d = wait_q - 1'b1;
          end
`else
          valid_d = 1'b1;
`endif
        end
      end
      RELEASE: begin
        if (!bus_request) begin
          state_d = IDLE;
        end
      end
      ERR: begin
        state_d = RELEASE;
        if (err_cnt_q != 8'hFF) begin
          err_cnt_d = err_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= IDLE;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      size_q      <= '0;
      last_beat_q <= '0;
      beat_q      <= '0;
      grant_q     <= 1'b0;
      valid_q     <= 1'b0;
      error_q     <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      grant_q   <= grant_d;
      valid_q   <= valid_d;
      error_q   <= error_d;
      err_cnt_q <= err_cnt_d;
      if (state_q == IDLE && bus_request) begin
        rw_q        <= bus_read_write;
        addr_q      <= bus_addr;
        size_q      <= bus_size;
        last_beat_q <= last_beat_of(bus_size);
      end
    end
  end

  // Writes land on the beat itself; reads are issued one cycle ahead using the
  // next beat index so the registered RAM output lines up with bus_valid.
  assign idx_q    = addr_q[AW+1:2];
  assign mem_we   = (state_q == BEAT) && valid_q && bus_request && rw_q;
  assign mem_addr = mem_we ? (idx_q + AW'(beat_q)) : (idx_q + AW'(beat_d));

  ip_codma_resp_mem #(
    .DEPTH (MEM_WORDS),
    .AW    (AW)
  ) u_mem (
    .clk_i (clk_i),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (bus_data_write),
    .rdata (mem_rdata)
  );

  assign bus_grant     = grant_q;
  assign bus_valid     = valid_q;
  assign bus_data_read = (valid_q && !rw_q) ? mem_rdata : 32'd0;
  assign bus_error     = error_q;
  assign busy_o        = (state_q != IDLE);
  assign err_count_o   = err_cnt_q;

endmodule

// File: tb/tb_ip_codma_bus_responder.sv
// Self-checking bench for ip_codma_bus_responder. Expected cycle timing and
// memory contents come from a word-array model and the transaction rules.
module tb_ip_codma_bus_responder;
  import ip_codma_pkg::*;

  localparam int unsigned MEM_WORDS = 256;
`ifdef CODMA_RESP_WAIT_EN
  localparam int W = 2;
`else
  localparam int W = 0;
`endif

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        bus_request = 1'b0;
  logic        bus_read_write = 1'b0;
  logic [31:0] bus_addr = '0;
  logic [3:0]  bus_size = '0;
  logic [31:0] bus_data_write = '0;
  logic        bus_grant;
  logic        bus_valid;
  logic [31:0] bus_data_read;
  logic        bus_error;
  logic        busy_o;
  logic [7:0]  err_count_o;

  ip_codma_bus_responder #(
    .MEM_WORDS   (MEM_WORDS),
    .WAIT_CYCLES (2)
  ) dut (
    .clk_i          (clk_i),
    .rstn_i         (rstn_i),
    .bus_request    (bus_request),
    .bus_read_write (bus_read_write),
    .bus_addr       (bus_addr),
    .bus_size       (bus_size),
    .bus_data_write (bus_data_write),
    .bus_grant      (bus_grant),
    .bus_valid      (bus_valid),
    .bus_data_read  (bus_data_read),
    .bus_error      (bus_error),
    .busy_o         (busy_o),
    .err_count_o    (err_count_o)
  );

  always #5 clk_i = ~clk_i;

  logic [31:0] model [MEM_WORDS];
  bit          known [MEM_WORDS];
  logic [31:0] wbuf [8];
  int          errs_exp = 0;
  int          pass_cnt = 0;
  int          chk_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt = chk_cnt + 1;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic fill_rand();
    for (int k = 0; k < 8; k++) wbuf[k] = $urandom;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_grant"}, 32'(bus_grant), 32'd0);
    chk({tag, "_valid"}, 32'(bus_valid), 32'd0);
    chk({tag, "_rdata"}, bus_data_read, 32'd0);
    chk({tag, "_error"}, 32'(bus_error), 32'd0);
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_errcnt"}, 32'(err_count_o), 32'd0);
  endtask

  // One full transaction, checked cycle by cycle. Cycle n = 0 is the cycle the
  // request is first seen; grant is expected from n = 2, beats every 1+W cycles
  // starting at n = 3+W, error pulse at n = 2 for illegal requests.
  task automatic xfer(input logic rw, input logic [31:0] addr, input logic [3:0] size);
    longint idx;
    int     beats, first_v, last_v, end_n, vcnt;
    bit     legal, exp_v, exp_g, exp_e;
    idx     = longint'(addr[31:2]);
    beats   = (size == SIZE_BURST) ? 8 : 1;
    legal   = (addr[1:0] == 2'b00) && (size == SIZE_WORD || size == SIZE_BURST)
              && (idx + longint'(beats) <= longint'(MEM_WORDS));
    first_v = 3 + W;
    last_v  = first_v + (beats - 1) * (1 + W);
    end_n   = legal ? last_v + 3 : 5;
    vcnt    = 0;
    bus_request    = 1'b1;
    bus_read_write = rw;
    bus_addr       = addr;
    bus_size       = size;
    bus_data_write = wbuf[0];
    for (int n = 1; n <= end_n; n++) begin
      @(negedge clk_i);
      exp_g = legal && n >= 2 && n <= last_v;
      exp_v = legal && n >= first_v && n <= last_v && ((n - first_v) % (1 + W)) == 0;
      exp_e = !legal && n == 2;
      chk("grant", 32'(bus_grant), 32'(exp_g));
      chk("valid", 32'(bus_valid), 32'(exp_v));
      chk("error", 32'(bus_error), 32'(exp_e));
      chk("busy", 32'(busy_o), 32'd1);
      if (exp_v && !rw && known[int'(idx) + vcnt]) begin
        chk("rdata", bus_data_read, model[int'(idx) + vcnt]);
      end
      // Request fields after the sampling cycle must be ignored.
      bus_addr       = $urandom;
      bus_size       = 4'($urandom_range(0, 15));
      bus_read_write = 1'($urandom_range(0, 1));
      if (vcnt < 8) bus_data_write = wbuf[vcnt];
      if (exp_v) vcnt++;
    end
    if (!legal) errs_exp = (errs_exp == 255) ? 255 : errs_exp + 1;
    chk("err_count", 32'(err_count_o), 32'(errs_exp));
    bus_request = 1'b0;
    @(negedge clk_i);
    chk("idle_after", 32'(busy_o), 32'd0);
    if (legal && rw) begin
      for (int k = 0; k < beats; k++) begin
        model[int'(idx) + k] = wbuf[k];
        known[int'(idx) + k] = 1'b1;
      end
    end
  endtask

  // Burst write dropped after its third beat.
  task automatic abort_write(input logic [31:0] addr);
    int idx, vcnt, n;
    idx  = int'(addr[31:2]);
    vcnt = 0;
    n    = 0;
    bus_request    = 1'b1;
    bus_read_write = 1'b1;
    bus_addr       = addr;
    bus_size       = SIZE_BURST;
    bus_data_write = wbuf[0];
    while (vcnt < 3 && n < 60) begin
      @(negedge clk_i);
      n++;
      bus_data_write = wbuf[vcnt];
      if (bus_valid) vcnt++;
    end
    chk("abort_beats_seen", 32'(vcnt), 32'd3);
    @(negedge clk_i);
    chk("abort_grant_held", 32'(bus_grant), 32'd1);
    bus_request    = 1'b0;
    bus_data_write = wbuf[3];
    @(negedge clk_i);
    chk("abort_grant_drop", 32'(bus_grant), 32'd0);
    chk("abort_valid_drop", 32'(bus_valid), 32'd0);
    chk("abort_no_error", 32'(bus_error), 32'd0);
    @(negedge clk_i);
    chk("abort_busy", 32'(busy_o), 32'd0);
    for (int k = 0; k < 3; k++) begin
      model[idx + k] = wbuf[k];
      known[idx + k] = 1'b1;
    end
  endtask

  task automatic reset_mid_read(input logic [31:0] addr);
    int vcnt, n;
    vcnt = 0;
    n    = 0;
    bus_request    = 1'b1;
    bus_read_write = 1'b0;
    bus_addr       = addr;
    bus_size       = SIZE_BURST;
    while (vcnt < 3 && n < 60) begin
      @(negedge clk_i);
      n++;
      if (bus_valid) vcnt++;
    end
    chk("rst_beats_seen", 32'(vcnt), 32'd3);
    #2;
    rstn_i = 1'b0;
    #1;
    chk_outputs_zero("rst_async");
    @(negedge clk_i);
    rstn_i      = 1'b1;
    bus_request = 1'b0;
    @(negedge clk_i);
    chk("rst_idle_busy", 32'(busy_o), 32'd0);
    chk("rst_idle_grant", 32'(bus_grant), 32'd0);
    errs_exp = 0;
    for (int i = 0; i < int'(MEM_WORDS); i++) known[i] = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    logic [3:0]  sz;
    int          sel;
    for (int i = 0; i < int'(MEM_WORDS); i++) begin
      model[i] = '0;
      known[i] = 1'b0;
    end
    fill_rand();

    // Reset state
    @(negedge clk_i);
    chk_outputs_zero("reset");
    @(negedge clk_i);
    rstn_i = 1'b1;
    @(negedge clk_i);
    chk_outputs_zero("post_reset");

    // Single write then single read of word 4
    wbuf[0] = 32'hCAFE_0001;
    xfer(1'b1, 32'h10, SIZE_WORD);
    xfer(1'b0, 32'h10, SIZE_WORD);

    // Burst write 1..8 at 0x20, then burst read
    for (int k = 0; k < 8; k++) wbuf[k] = 32'(k + 1);
    xfer(1'b1, 32'h20, SIZE_BURST);
    xfer(1'b0, 32'h20, SIZE_BURST);

    // Illegal requests as writes; memory must stay put
    fill_rand();
    xfer(1'b1, 32'h22, SIZE_WORD);
    xfer(1'b1, 32'h20, 4'd5);
    xfer(1'b1, 32'((MEM_WORDS - 4) * 4), SIZE_BURST);
    chk("err_count_three", 32'(err_count_o), 32'd3);
    xfer(1'b0, 32'h20, SIZE_BURST);
    xfer(1'b0, 32'h10, SIZE_WORD);

    // Boundary-legal accesses at the top of memory
    fill_rand();
    xfer(1'b1, 32'((MEM_WORDS - 8) * 4), SIZE_BURST);
    xfer(1'b0, 32'((MEM_WORDS - 8) * 4), SIZE_BURST);
    fill_rand();
    xfer(1'b1, 32'((MEM_WORDS - 1) * 4), SIZE_WORD);
    xfer(1'b0, 32'((MEM_WORDS - 1) * 4), SIZE_WORD);
    xfer(1'b1, 32'(MEM_WORDS * 4), SIZE_WORD);

    // Abort after the third beat of a burst write
    fill_rand();
    xfer(1'b1, 32'h100, SIZE_BURST);
    fill_rand();
    abort_write(32'h100);
    xfer(1'b0, 32'h100, SIZE_BURST);

    // Randomized write/read pairs, legal and illegal
    for (int t = 0; t < 40; t++) begin
      sel = $urandom_range(0, 9);
      if (sel < 5)      sz = SIZE_WORD;
      else if (sel < 9) sz = SIZE_BURST;
      else              sz = 4'($urandom_range(0, 15));
      a = 32'($urandom_range(0, MEM_WORDS + 3)) << 2;
      if ($urandom_range(0, 9) == 0) a[1:0] = 2'($urandom_range(1, 3));
      fill_rand();
      xfer(1'b1, a, sz);
      xfer(1'b0, a, sz);
    end

    // Asynchronous reset in the middle of a burst read, then normal service
    reset_mid_read(32'h20);
    fill_rand();
    xfer(1'b1, 32'h40, SIZE_WORD);
    xfer(1'b0, 32'h40, SIZE_WORD);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
